oled_spi_arbiter: RTL and testbench
===================================

Name: oled_spi_arbiter

Overview:
Shares the single OLED serial shift register between two byte sources: the SSD1306 init sequencer (requester 0) and the display/frequency-digit writer (requester 1).
Arbitrates at burst granularity and sequences each byte onto the shift register's start/ready interface.
Owns oled_csn and oled_dc, so neither requester drives the pins directly.
Sits between the requesters and shift_register, in the clk_1M domain.

Parameters:
CS_SETUP, 1, cycles csn is low with dc valid before the first sr_start of a burst (also used before each later byte)
CS_HOLD, 2, cycles csn stays low after the last byte completes
ACK_TIMEOUT, 8, max cycles to wait for sr_ready to fall after sr_start; range 1..255

Ports:
clk_in  input  1  block clock (clk_1M)
resetn  input  1  asynchronous, active-low reset
req_valid  input  2  per-requester byte valid (bit0 = init, bit1 = display)
req_data0  input  8  requester 0 byte
req_data1  input  8  requester 1 byte
req_dc  input  2  per-requester D/C flag (0 = command, 1 = data)
req_last  input  2  per-requester last-byte-of-burst flag
req_ready  output  2  one-cycle accept strobe to the granted requester
sr_start  output  1  one-cycle start pulse to shift_register
sr_data  output  8  byte to shift_register, held stable from ISSUE until WAIT_DONE exits
sr_ready  input  1  shift_register idle flag (1 = idle)
oled_csn  output  1  OLED chip select, active low
oled_dc  output  1  OLED data/command select
grant  output  2  one-hot owner of the current burst; 0 when idle
busy  output  1  1 in any state other than IDLE
err_timeout  output  1  one-cycle pulse when ACK_TIMEOUT expires

Behaviour:
- Reset (async assert, sync release): state IDLE, oled_csn = 1, oled_dc = 0, sr_start = 0, sr_data = 0, req_ready = 0, grant = 0, busy = 0, err_timeout = 0, counters = 0.
- Assertion mid-burst aborts immediately: csn rises and no further start pulse is issued.
- Requester contract:
  - Hold valid/data/dc/last stable until req_ready is seen.
  - The byte is transferred in the cycle req_ready = 1.
  - valid may drop only after acceptance.
- FSM states: IDLE, SETUP, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, HOLD, GAP.
- IDLE:
  - If req_valid != 0, grant the lowest set bit (init has fixed priority).
  - A grant is never pre-empted inside a burst.
  - Latch the granted data, dc and last; go to SETUP.
- SETUP:
  - oled_csn = 0; oled_dc = latched dc.
  - Count CS_SETUP cycles, then go to ISSUE.
- ISSUE (exactly 1 cycle): sr_start = 1, sr_data = latched byte, req_ready[grant] = 1. Go to WAIT_ACK.
- WAIT_ACK:
  - Wait for sr_ready = 0.
  - If sr_ready stays 1 for ACK_TIMEOUT cycles: err_timeout = 1 for one cycle, then go to HOLD. The burst is abandoned and grant is released after GAP.
- WAIT_DONE: wait for sr_ready = 1.
  - If the latched last = 1, go to HOLD.
  - Otherwise go to NEXT.
- NEXT:
  - csn stays low; wait for req_valid[grant].
  - On valid, latch the new byte/dc/last and go to SETUP. oled_dc may change here, but only while the shift register is idle.
  - The other requester's valid is ignored while in NEXT.
- HOLD: csn low for CS_HOLD cycles, then go to GAP.
- GAP (exactly 1 cycle): oled_csn = 1, grant = 0, then go to IDLE. This guarantees at least 1 cycle of csn high between bursts.
- Simultaneous valid in IDLE: init wins. The display writer is served after the init burst's GAP.
- A requester whose valid rises during another burst waits and receives no req_ready.
- sr_ready already 0 when entering ISSUE (should not occur): still pulse start, then proceed normally.
- Minimum single-byte burst length: 1 + CS_SETUP + 1 + ack + shift + 1 + CS_HOLD + 1 cycles (the leading 1 is the IDLE cycle).
- Counters saturate; no wrap-around is possible.

Test Plan:
- Single byte, init, dc = 0, last = 1, model ready falls 1 cycle after start and stays low 16 cycles → one sr_start carrying that byte; csn low from the SETUP cycle through HOLD + 2; oled_dc = 0; grant = 01; req_ready[0] pulses exactly once.
- Three-byte display burst (data 0xA5, 0x5A, 0xFF, dc = 1, last on byte 3) → three starts in order; csn low continuously; oled_dc = 1; no GAP between bytes.
- Both valid in the same IDLE cycle → init burst completes fully, csn high ≥ 1 cycle, then the display burst starts; req_ready[1] stays 0 during the init burst.
- Shift model never drops ready, ACK_TIMEOUT = 8 → err_timeout pulses on the 8th WAIT_ACK cycle; csn rises after HOLD + GAP; FSM returns to IDLE and accepts a new request.
- resetn asserted during WAIT_DONE of a burst → same cycle: csn = 1, sr_start = 0, grant = 0; after release, a pending init request is served from IDLE.
- dc change inside a burst (byte 1 dc = 0, byte 2 dc = 1) → oled_dc toggles only in NEXT/SETUP while sr_ready = 1, never while shifting.

Source files
------------

// File: rtl/oled_spi_arbiter_if.sv
// Bundle of requester, shift-register and OLED pin signals around oled_spi_arbiter.
// Handshake: a requester holds valid/data/dc/last stable until req_ready pulses; the byte moves in that cycle.
interface oled_spi_arbiter_if;
    logic [1:0] req_valid;
    logic [7:0] req_data0;
    logic [7:0] req_data1;
    logic [1:0] req_dc;
    logic [1:0] req_last;
    logic [1:0] req_ready;
    logic       sr_start;
    logic [7:0] sr_data;
    logic       sr_ready;
    logic       oled_csn;
    logic       oled_dc;
    logic [1:0] grant;
    logic       busy;
    logic       err_timeout;
    logic [2:0] dbg_state;

    modport slave (
        input  req_valid, req_data0, req_data1, req_dc, req_last, sr_ready,
        output req_ready, sr_start, sr_data, oled_csn, oled_dc, grant, busy, err_timeout, dbg_state
    );

    modport master (
        output req_valid, req_data0, req_data1, req_dc, req_last, sr_ready,
        input  req_ready, sr_start, sr_data, oled_csn, oled_dc, grant, busy, err_timeout, dbg_state
    );
endinterface

// File: rtl/oled_spi_arbiter.sv
// Burst-granular arbiter sharing the OLED shift register between the init sequencer (0) and display writer (1).
// Owns oled_csn/oled_dc; CS_SETUP, CS_HOLD and ACK_TIMEOUT are expected to be at least 1.
module oled_spi_arbiter #(
    parameter int CS_SETUP    = 1,
    parameter int CS_HOLD     = 2,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic               clk_in,
    input  logic               resetn,
    oled_spi_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        ISSUE     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4,
        NEXT      = 3'd5,
        HOLD      = 3'd6,
        GAP       = 3'd7
    } state_t;

    localparam logic [7:0] SETUP_END = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_END  = 8'(CS_HOLD - 1);
    localparam logic [7:0] ACK_END   = 8'(ACK_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
    logic       dc_q, dc_d;
    logic       last_q, last_d;
    logic [1:0] grant_q, grant_d;

    logic       start_c;
    logic [1:0] ready_c;
    logic       err_c;
    logic       pick1;
    logic [7:0] cnt_inc;

    // In NEXT the owner is fixed; in IDLE requester 0 wins any tie.
    assign pick1   = (state_q == NEXT) ? grant_q[1] : !bus.req_valid[0];
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk_in or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            data_q  <= 8'd0;
            dc_q    <= 1'b0;
            last_q  <= 1'b0;
            grant_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            dc_q    <= dc_d;
            last_q  <= last_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        dc_d    = dc_q;
        last_d  = last_q;
        grant_d = grant_q;
        start_c = 1'b0;
        ready_c = 2'b00;
        err_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid != 2'b00) begin
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    data_d  = pick1 ? bus.req_data1 : bus.req_data0;
                    dc_d    = bus.req_dc[pick1];
                    last_d  = bus.req_last[pick1];
                    cnt_d   = 8'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q >= SETUP_END) begin
                    cnt_d   = 8'd0;
                    state_d = ISSUE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ISSUE: begin
                start_c = 1'b1;
                ready_c = grant_q;
                cnt_d   = 8'd0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!bus.sr_ready) begin
                    cnt_d   = 8'd0;
                    state_d = WAIT_DONE;
                end else if (cnt_q >= ACK_END) begin
                    // Shift register never acknowledged: abandon the burst.
                    err_c   = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (bus.sr_ready) begin
                    cnt_d   = 8'd0;
                    state_d = last_q ? HOLD : NEXT;
                end
            end
            NEXT: begin
                if ((bus.req_valid & grant_q) != 2'b00) begin
                    data_d  = pick1 ? bus.req_data1 : bus.req_data0;
                    dc_d    = bus.req_dc[pick1];
                    last_d  = bus.req_last[pick1];
                    cnt_d   = 8'd0;
                    state_d = SETUP;
                end
            end
            HOLD: begin
                if (cnt_q >= HOLD_END) begin
                    cnt_d   = 8'd0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GAP: begin
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sr_start    = start_c;
    assign bus.req_ready   = ready_c;
    assign bus.err_timeout = err_c;
    assign bus.sr_data     = data_q;
    assign bus.oled_dc     = dc_q;
    assign bus.oled_csn    = (state_q == IDLE) || (state_q == GAP);
    assign bus.grant       = (state_q == GAP) ? 2'b00 : grant_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_oled_spi_arbiter.sv
// Randomised scoreboard bench for oled_spi_arbiter: requester drivers, shift-register model, byte-order reference.
module tb_oled_spi_arbiter;
    localparam int ACK_TIMEOUT = 8;
    localparam int EW = 12;                 // {first, grant[1:0], dc, data[7:0]}
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    logic clk_in = 1'b0;
    logic resetn = 1'b0;
    always #5 clk_in = ~clk_in;

    oled_spi_arbiter_if bus();

    logic       v0 = 1'b0, v1 = 1'b0, dc0 = 1'b0, dc1 = 1'b0, l0 = 1'b0, l1 = 1'b0;
    logic [7:0] d0 = 8'd0, d1 = 8'd0;
    logic       sr_ready = 1'b1;

    assign bus.req_valid = {v1, v0};
    assign bus.req_data0 = d0;
    assign bus.req_data1 = d1;
    assign bus.req_dc    = {dc1, dc0};
    assign bus.req_last  = {l1, l0};
    assign bus.sr_ready  = sr_ready;

    oled_spi_arbiter #(.CS_SETUP(1), .CS_HOLD(2), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk_in (clk_in),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int exp_err = 0;
    logic [EW-1:0] exp_q[$];

    logic [7:0] b_data [2][8];
    logic       b_dc   [2][8];
    int         b_len  [2];

    bit no_ack = 1'b0;
    bit fixed_timing = 1'b0;
    int fixed_shift = 16;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Shift-register model: ready falls some cycles after start, stays low while shifting.
    initial begin
        forever begin
            @(negedge clk_in);
            if (resetn && bus.sr_start && !no_ack) begin
                int a;
                int s;
                a = fixed_timing ? 0 : $urandom_range(0, 3);
                s = fixed_timing ? fixed_shift : $urandom_range(2, 8);
                repeat (a) @(negedge clk_in);
                sr_ready = 1'b0;
                for (int k = 0; k < s && resetn; k++) @(negedge clk_in);
                sr_ready = 1'b1;
            end
        end
    end

    // Monitor: every start must match the next expected byte; invariants on req_ready, csn and dc.
    bit   csn_hi_seen = 1'b1;
    logic prev_dc = 1'b0;
    always @(negedge clk_in) begin
        logic [EW-1:0] e;
        if (!resetn) begin
            csn_hi_seen = 1'b1;
            prev_dc = 1'b0;
        end else begin
            if (bus.oled_csn) csn_hi_seen = 1'b1;
            if (bus.err_timeout) err_seen++;
            if (bus.oled_dc !== prev_dc) chk("dc_change_while_shifting", {31'd0, sr_ready}, 32'd1);
            prev_dc = bus.oled_dc;
            if (bus.req_ready != 2'b00)
                chk("req_ready_vs_grant", {29'd0, bus.sr_start, bus.req_ready}, {29'd0, 1'b1, bus.grant});
            if (bus.sr_start) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_start", {24'd0, bus.sr_data}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("sr_data", {24'd0, bus.sr_data}, {24'd0, e[7:0]});
                    chk("oled_dc", {31'd0, bus.oled_dc}, {31'd0, e[8]});
                    chk("grant", {30'd0, bus.grant}, {30'd0, e[10:9]});
                    chk("csn_low_at_start", {31'd0, bus.oled_csn}, 32'd0);
                    chk("csn_gap_vs_burst_start", {31'd0, csn_hi_seen}, {31'd0, e[11]});
                end
                csn_hi_seen = 1'b0;
            end
        end
    end

    task automatic set_req(input int r, input logic v, input logic [7:0] d, input logic dc, input logic l);
        if (r == 0) begin v0 = v; d0 = d; dc0 = dc; l0 = l; end
        else begin v1 = v; d1 = d; dc1 = dc; l1 = l; end
    endtask

    task automatic drive_req(input int r);
        for (int i = 0; i < b_len[r]; i++) begin
            int t;
            if (i > 0) repeat ($urandom_range(0, 3)) @(negedge clk_in);
            set_req(r, 1'b1, b_data[r][i], b_dc[r][i], (i == b_len[r] - 1));
            t = 0;
            do begin
                @(negedge clk_in);
                t++;
            end while (!bus.req_ready[r] && t < 2000);
            if (!bus.req_ready[r]) begin
                chk("req_ready_timeout", 32'(r), 32'hFFFF_FFFF);
                set_req(r, 1'b0, 8'd0, 1'b0, 1'b0);
                return;
            end
            set_req(r, 1'b0, 8'd0, 1'b0, 1'b0);
        end
    endtask

    // Reference order: fixed priority means any init burst goes out before a same-time display burst.
    task automatic push_expected(input bit use0, input bit use1);
        if (use0) for (int i = 0; i < b_len[0]; i++) exp_q.push_back({(i == 0), 2'b01, b_dc[0][i], b_data[0][i]});
        if (use1) for (int i = 0; i < b_len[1]; i++) exp_q.push_back({(i == 0), 2'b10, b_dc[1][i], b_data[1][i]});
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((bus.busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk_in);
            t++;
        end
        chk("drain", {31'd0, (bus.busy || exp_q.size() != 0)}, 32'd0);
        @(negedge clk_in);
    endtask

    task automatic run_scen(input bit use0, input bit use1);
        push_expected(use0, use1);
        fork
            begin if (use0) drive_req(0); end
            begin if (use1) drive_req(1); end
        join
        wait_idle();
    endtask

    task automatic rand_burst(input int r);
        b_len[r] = $urandom_range(1, 4);
        for (int i = 0; i < b_len[r]; i++) begin
            b_data[r][i] = 8'($urandom_range(0, 255));
            b_dc[r][i]   = 1'($urandom_range(0, 1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_in);
        chk("rst_csn", {31'd0, bus.oled_csn}, 32'd1);
        chk("rst_dc", {31'd0, bus.oled_dc}, 32'd0);
        chk("rst_start", {31'd0, bus.sr_start}, 32'd0);
        chk("rst_data", {24'd0, bus.sr_data}, 32'd0);
        chk("rst_outs", {26'd0, bus.req_ready, bus.grant, bus.busy, bus.err_timeout}, 32'd0);
        resetn = 1'b1;
        @(negedge clk_in);

        // Single init command byte with fixed shift timing.
        fixed_timing = 1'b1;
        b_len[0] = 1; b_data[0][0] = 8'hAE; b_dc[0][0] = 1'b0;
        run_scen(1'b1, 1'b0);
        fixed_timing = 1'b0;

        // Three-byte display data burst.
        b_len[1] = 3;
        b_data[1][0] = 8'hA5; b_data[1][1] = 8'h5A; b_data[1][2] = 8'hFF;
        for (int i = 0; i < 3; i++) b_dc[1][i] = 1'b1;
        run_scen(1'b0, 1'b1);

        // Simultaneous requests: init then display.
        b_len[0] = 2; b_data[0][0] = 8'h20; b_data[0][1] = 8'h00; b_dc[0][0] = 1'b0; b_dc[0][1] = 1'b0;
        b_len[1] = 2; b_data[1][0] = 8'h11; b_data[1][1] = 8'h22; b_dc[1][0] = 1'b1; b_dc[1][1] = 1'b1;
        run_scen(1'b1, 1'b1);

        // dc toggles between bytes of one burst.
        b_len[0] = 2; b_data[0][0] = 8'hB0; b_data[0][1] = 8'h7E; b_dc[0][0] = 1'b0; b_dc[0][1] = 1'b1;
        run_scen(1'b1, 1'b0);

        // Shift register never acknowledges.
        no_ack = 1'b1;
        exp_err++;
        b_len[0] = 1; b_data[0][0] = 8'hC3; b_dc[0][0] = 1'b0;
        fork
            run_scen(1'b1, 1'b0);
            begin
                int t;
                t = 0;
                do begin @(negedge clk_in); t++; end while (!bus.sr_start && t < 200);
                t = 0;
                do begin @(negedge clk_in); t++; end while (!bus.err_timeout && t < 50);
                chk("timeout_latency", 32'(t), 32'(ACK_TIMEOUT));
                @(negedge clk_in); chk("timeout_hold1_csn", {31'd0, bus.oled_csn}, 32'd0);
                @(negedge clk_in); chk("timeout_hold2_csn", {31'd0, bus.oled_csn}, 32'd0);
                @(negedge clk_in); chk("timeout_gap", {28'd0, bus.oled_csn, bus.grant, bus.busy}, {28'd0, 1'b1, 2'b00, 1'b1});
                @(negedge clk_in); chk("timeout_idle_busy", {31'd0, bus.busy}, 32'd0);
            end
        join
        no_ack = 1'b0;
        b_len[0] = 1; b_data[0][0] = 8'h3D; b_dc[0][0] = 1'b1;
        run_scen(1'b1, 1'b0);

        // Reset asserted while the shift register is busy.
        fixed_timing = 1'b1;
        fixed_shift = 20;
        b_len[0] = 1; b_data[0][0] = 8'h5C; b_dc[0][0] = 1'b1;
        push_expected(1'b1, 1'b0);
        drive_req(0);
        begin
            int t;
            t = 0;
            while (bus.dbg_state !== ST_WAIT_DONE && t < 100) begin @(negedge clk_in); t++; end
            chk("reached_wait_done", {29'd0, bus.dbg_state}, {29'd0, ST_WAIT_DONE});
        end
        #2 resetn = 1'b0;
        #1;
        chk("abort_csn", {31'd0, bus.oled_csn}, 32'd1);
        chk("abort_start", {31'd0, bus.sr_start}, 32'd0);
        chk("abort_grant", {30'd0, bus.grant}, 32'd0);
        fixed_timing = 1'b0;
        fixed_shift = 16;
        b_len[0] = 1; b_data[0][0] = 8'h81; b_dc[0][0] = 1'b0;
        push_expected(1'b1, 1'b0);
        fork
            drive_req(0);
            begin repeat (2) @(negedge clk_in); resetn = 1'b1; end
        join
        wait_idle();

        // Randomised bursts.
        for (int n = 0; n < 40; n++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rand_burst(0);
            rand_burst(1);
            run_scen(pat[0], pat[1]);
        end

        chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
        chk("err_timeout_count", 32'(err_seen), 32'(exp_err));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
